// File: rtl/mem_map_pkg.sv
// Shared command encodings, address map and decode region type for the
// memory responder and its testbench.
package mem_map_pkg;

    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam logic [1:0] MEM_WRITE   = 2'b01;
    localparam logic [1:0] MEM_READ    = 2'b10;
    localparam logic [1:0] MEM_ILLEGAL = 2'b11;

    localparam logic [8:0] RAM_BASE    = 9'h000;
    localparam logic [8:0] LED_ADDR    = 9'h100;
    localparam logic [8:0] SW_ADDR     = 9'h140;
    localparam logic [8:0] TIMER_ADDR  = 9'h180;
    localparam logic [8:0] STATUS_ADDR = 9'h1C0;

    localparam int unsigned TIMER_WIDTH = 16;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_TIMER,
        REG_STATUS,
        REG_NONE
    } region_t;

endpackage

// File: rtl/ram_1p.sv
module ram_1p #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 256,
  parameter string       INIT_FILE  = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side target: RAM, LED/SW/TIMER I/O registers and STATUS, with
// one-cycle read latency and a sticky protocol/decode error flag.
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned LED_WIDTH  = 10,
    parameter int unsigned SW_WIDTH   = 10,
    parameter int unsigned TICK_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mem_cmd,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid,
    input  logic [SW_WIDTH-1:0]   sw,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  err
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    function automatic region_t decode(input logic [ADDR_WIDTH-1:0] a);
        if ((a - ADDR_WIDTH'(RAM_BASE)) < ADDR_WIDTH'(RAM_WORDS)) decode = REG_RAM;
        else if (a == ADDR_WIDTH'(LED_ADDR))                      decode = REG_LED;
        else if (a == ADDR_WIDTH'(SW_ADDR))                       decode = REG_SW;
        else if (a == ADDR_WIDTH'(TIMER_ADDR))                    decode = REG_TIMER;
        else if (a == ADDR_WIDTH'(STATUS_ADDR))                   decode = REG_STATUS;
        else                                                      decode = REG_NONE;
    endfunction

    region_t                region;
    logic                   is_read;
    logic                   is_write;
    logic                   ram_en;
    logic                   ram_we;
    logic [RAM_AW-1:0]      ram_addr;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic [DATA_WIDTH-1:0]  io_rdata;
    logic                   err_set;
    logic                   err_clr;
    logic                   rd_sel_ram;
    logic [DATA_WIDTH-1:0]  rd_hold;
    logic [SW_WIDTH-1:0]    sw_meta;
    logic [SW_WIDTH-1:0]    sw_sync;
    logic [PW-1:0]          presc;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timer_wr;
    logic                   tick;

    always_comb begin
        region   = decode(mem_addr);
        is_read  = (mem_cmd == MEM_READ);
        is_write = (mem_cmd == MEM_WRITE);
        ram_en   = is_read  && (region == REG_RAM);
        ram_we   = is_write && (region == REG_RAM);
        ram_addr = RAM_AW'(mem_addr - ADDR_WIDTH'(RAM_BASE));
        timer_wr = is_write && (region == REG_TIMER);
        tick     = (presc == PW'(TICK_DIV - 1));
        err_clr  = is_write && (region == REG_STATUS) && mem_wdata[0];
        err_set  = (mem_cmd == MEM_ILLEGAL)
                 || (is_read  && (region == REG_NONE))
                 || (is_write && ((region == REG_NONE) || (region == REG_SW)));

        io_rdata = '0;
        case (region)
            REG_LED:    io_rdata = DATA_WIDTH'(led);
            REG_SW:     io_rdata = DATA_WIDTH'(sw_sync);
            REG_TIMER:  io_rdata = DATA_WIDTH'(timer);
            REG_STATUS: io_rdata = DATA_WIDTH'(err);
            default:    io_rdata = '0;
        endcase
    end

    ram_1p #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RAM_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(mem_wdata),
        .rdata(ram_q)
    );

    // RAM data is already registered inside ram_1p; non-RAM read data is
    // captured here, and the selector picks which register drives the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rvalid <= 1'b0;
            rd_sel_ram <= 1'b0;
            rd_hold    <= '0;
        end else begin
            mem_rvalid <= is_read;
            if (is_read) begin
                rd_sel_ram <= (region == REG_RAM);
                rd_hold    <= io_rdata;
            end
        end
    end

    always_comb begin
        mem_rdata = rd_sel_ram ? ram_q : rd_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= '0;
            err     <= 1'b0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (is_write && (region == REG_LED)) led <= mem_wdata[LED_WIDTH-1:0];
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            timer <= '0;
        end else if (timer_wr) begin
            presc <= '0;
            timer <= mem_wdata[TIMER_WIDTH-1:0];
        end else if (tick) begin
            presc <= '0;
            timer <= timer + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a cycle-indexed
// reference model (timer as a function of elapsed cycles, sw as history).
module tb_mem_responder;
    import mem_map_pkg::*;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [9:0]  sw;
    logic [9:0]  led;
    logic        err;

    mem_responder #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(9),
        .RAM_WORDS (256),
        .LED_WIDTH (10),
        .SW_WIDTH  (10),
        .TICK_DIV  (TD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .sw        (sw),
        .led       (led),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned cyc = 0;
    int unsigned rel = 0;
    int unsigned tbase_edge = 0;
    logic [15:0] tbase_val = '0;
    logic [15:0] ram_m [256];
    bit          ram_k [256];
    logic [9:0]  led_m = '0;
    bit          err_m = 1'b0;
    logic [9:0]  sw_at [int];
    bit          exp_valid = 1'b0;
    logic [15:0] exp_rdata = '0;
    bit          exp_known = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] timer_now();
        return tbase_val + 16'((cyc - tbase_edge) / TD);
    endfunction

    function automatic logic [9:0] sw_seen();
        if (cyc >= rel + 2) return sw_at[int'(cyc - 2)];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        rel        = cyc;
        tbase_edge = cyc;
        tbase_val  = '0;
        led_m      = '0;
        err_m      = 1'b0;
        exp_valid  = 1'b0;
        exp_rdata  = '0;
        exp_known  = 1'b1;
    endtask

    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        logic [15:0] rv;
        bit          known;
        rv    = '0;
        known = 1'b1;
        sw_at[int'(cyc)] = sw;
        if (c == MEM_READ) begin
            if (a < 9'h100)              begin rv = ram_m[a]; known = ram_k[a]; end
            else if (a == LED_ADDR)      rv = 16'(led_m);
            else if (a == SW_ADDR)       rv = 16'(sw_seen());
            else if (a == TIMER_ADDR)    rv = timer_now();
            else if (a == STATUS_ADDR)   rv = 16'(err_m);
            else                         err_m = 1'b1;
        end else if (c == MEM_WRITE) begin
            if (a < 9'h100)              begin ram_m[a] = d; ram_k[a] = 1'b1; end
            else if (a == LED_ADDR)      led_m = d[9:0];
            else if (a == TIMER_ADDR)    begin tbase_val = d; tbase_edge = cyc + 1; end
            else if (a == STATUS_ADDR)   begin if (d[0]) err_m = 1'b0; end
            else                         err_m = 1'b1;
        end else if (c == MEM_ILLEGAL) begin
            err_m = 1'b1;
        end
        mem_cmd   = c;
        mem_addr  = a;
        mem_wdata = d;
        tick();
        exp_valid = (c == MEM_READ);
        if (exp_valid) begin
            exp_rdata = rv;
            exp_known = known;
        end
        check("rvalid", 32'(mem_rvalid), 32'(exp_valid));
        if (exp_known) check("rdata", 32'(mem_rdata), 32'(exp_rdata));
        check("led", 32'(led), 32'(led_m));
        check("err", 32'(err), 32'(err_m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c;
        logic [8:0] a;
        int unsigned r;

        foreach (ram_k[i]) ram_k[i] = 1'b0;
        reset     = 1'b1;
        mem_cmd   = MEM_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        sw        = '0;
        tick();
        tick();
        check("rst_rdata", 32'(mem_rdata), 32'h0);
        check("rst_rvalid", 32'(mem_rvalid), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        model_reset();

        // RAM read latency and hold
        step(MEM_WRITE, 9'h005, 16'h1234);
        step(MEM_READ,  9'h005, 16'h0);
        check("ram5_rdata", 32'(mem_rdata), 32'h1234);
        check("ram5_rvalid", 32'(mem_rvalid), 32'h1);
        step(MEM_NONE,  9'h005, 16'h0);
        check("ram5_hold_rvalid", 32'(mem_rvalid), 32'h0);
        check("ram5_hold_rdata", 32'(mem_rdata), 32'h1234);

        step(MEM_WRITE, 9'h00A, 16'hBEEF);
        step(MEM_READ,  9'h00A, 16'h0);
        check("ramA_rdata", 32'(mem_rdata), 32'hBEEF);
        step(MEM_WRITE, 9'h00B, 16'h1111);
        step(MEM_WRITE, 9'h00C, 16'h2222);
        step(MEM_READ,  9'h00B, 16'h0);
        step(MEM_READ,  9'h00C, 16'h0);
        check("ramC_rdata", 32'(mem_rdata), 32'h2222);

        // LED / SW
        step(MEM_WRITE, LED_ADDR, 16'hFFFF);
        check("led_const", 32'(led), 32'h3FF);
        step(MEM_READ,  LED_ADDR, 16'h0);
        check("led_rd_const", 32'(mem_rdata), 32'h03FF);
        sw = 10'h155;
        step(MEM_NONE, 9'h0, 16'h0);
        step(MEM_NONE, 9'h0, 16'h0);
        step(MEM_READ, SW_ADDR, 16'h0);
        check("sw_rd_const", 32'(mem_rdata), 32'h0155);
        step(MEM_WRITE, SW_ADDR, 16'h0000);
        check("sw_wr_err", 32'(err), 32'h1);
        check("sw_wr_led", 32'(led), 32'h3FF);
        step(MEM_WRITE, STATUS_ADDR, 16'h0001);

        // Timer wrap and write/tick priority
        step(MEM_WRITE, TIMER_ADDR, 16'hFFFE);
        for (int i = 0; i < 8; i++) step(MEM_NONE, 9'h0, 16'h0);
        step(MEM_READ, TIMER_ADDR, 16'h0);
        check("timer_wrap_const", 32'(mem_rdata), 32'h0000);
        for (int i = 0; i < 8 && ((cyc - tbase_edge) % TD) != TD - 1; i++)
            step(MEM_NONE, 9'h0, 16'h0);
        step(MEM_WRITE, TIMER_ADDR, 16'h1357);
        step(MEM_READ, TIMER_ADDR, 16'h0);
        check("timer_prio_const", 32'(mem_rdata), 32'h1357);

        // Error conditions and STATUS
        step(MEM_ILLEGAL, 9'h005, 16'h0);
        check("illegal_err", 32'(err), 32'h1);
        check("illegal_rvalid", 32'(mem_rvalid), 32'h0);
        step(MEM_READ, 9'h1FF, 16'h0);
        check("unmapped_rdata", 32'(mem_rdata), 32'h0);
        check("unmapped_rvalid", 32'(mem_rvalid), 32'h1);
        step(MEM_READ, STATUS_ADDR, 16'h0);
        check("status_rd_const", 32'(mem_rdata), 32'h0001);
        step(MEM_WRITE, STATUS_ADDR, 16'h0000);
        check("status_wr0_err", 32'(err), 32'h1);
        step(MEM_WRITE, STATUS_ADDR, 16'h0001);
        check("status_wr1_err", 32'(err), 32'h0);

        // Reset while a read result is on the bus
        step(MEM_WRITE, 9'h010, 16'h5A5A);
        step(MEM_WRITE, LED_ADDR, 16'h0155);
        step(MEM_ILLEGAL, 9'h0, 16'h0);
        step(MEM_READ, 9'h010, 16'h0);
        mem_cmd = MEM_NONE;
        #1 reset = 1'b1;
        #1;
        check("midrst_rvalid", 32'(mem_rvalid), 32'h0);
        check("midrst_rdata", 32'(mem_rdata), 32'h0);
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        step(MEM_READ, 9'h010, 16'h0);
        check("ram_preserved", 32'(mem_rdata), 32'h5A5A);
        step(MEM_READ, TIMER_ADDR, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 32; i++) step(MEM_WRITE, 9'(i), 16'($urandom));
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) sw = 10'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 4)      a = 9'($urandom_range(0, 31));
            else if (r == 5) a = LED_ADDR;
            else if (r == 6) a = SW_ADDR;
            else if (r == 7) a = TIMER_ADDR;
            else if (r == 8) a = STATUS_ADDR;
            else             a = 9'h100 | 9'($urandom_range(1, 63));
            r = $urandom_range(0, 9);
            if (r <= 1)      c = MEM_NONE;
            else if (r <= 4) c = MEM_WRITE;
            else if (r <= 8) c = MEM_READ;
            else             c = MEM_ILLEGAL;
            step(c, a, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
